// File: rtl/rotate_sequencer.sv
// -----------------------------------------------------------------------------
// rotate_sequencer
//
// Upstream controller for the rotating shift register in the PWM loop.
// A configuration (pattern, initial direction, step period) is accepted over a
// valid/ready handshake. The block then issues a one-cycle load strobe, followed
// by single-cycle shift strobes spaced every period+1 clocks while run_i is
// high. Every WIDTH-th shift since the load is flagged on wrap_o.
//
// Optional feature macro: ROTATE_SEQ_BOUNCE_EN
//   defined   : ping-pong mode. After each wrap the direction toggles in the
//               cycle following the wrap shift, and stepping pauses for that
//               one cycle so the new direction is stable before the next shift.
//   undefined : direction stays at the captured cfg_dir_i until the next load.
//
// Parameters
//   WIDTH  pattern width (equals the downstream register width, >= 2)
//   DIV_W  width of the step-period prescaler
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   cfg_valid_i    configuration offered
//   cfg_ready_o    configuration can be accepted (combinational: state != LOAD)
//   cfg_pattern_i  pattern to load
//   cfg_dir_i      initial direction, 0 = left, 1 = right
//   cfg_period_i   shift every cfg_period_i+1 clocks
//   run_i          1 = stepping enabled, 0 = pause (prescaler holds)
//   stop_i         return to IDLE, no further strobes
//   load_o         one-cycle load strobe (registered)
//   shift_o        one-cycle shift strobe (registered)
//   dir_o          direction to the register (registered)
//   data_in_o      pattern to the register, valid while load_o = 1
//   busy_o         1 while not IDLE (registered)
//   wrap_o         pulses with the shift that completes WIDTH shifts
// -----------------------------------------------------------------------------
module rotate_sequencer #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [WIDTH-1:0] cfg_pattern_i,
    input  logic             cfg_dir_i,
    input  logic [DIV_W-1:0] cfg_period_i,
    input  logic             run_i,
    input  logic             stop_i,
    output logic             load_o,
    output logic             shift_o,
    output logic             dir_o,
    output logic [WIDTH-1:0] data_in_o,
    output logic             busy_o,
    output logic             wrap_o
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] STEP_ONE   = CNT_W'(1);
    localparam logic [DIV_W-1:0] PRESC_ONE  = DIV_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t             state_q,   state_d;
    logic [DIV_W-1:0]   presc_q,   presc_d;
    logic [CNT_W-1:0]   step_q,    step_d;
    logic [DIV_W-1:0]   period_q,  period_d;
    logic               load_q,    load_d;
    logic               shift_q,   shift_d;
    logic               wrap_q,    wrap_d;
    logic               dir_q,     dir_d;
    logic [WIDTH-1:0]   data_q,    data_d;
    logic               busy_q,    busy_d;

    // -------------------------------------------------------------------------
    // Helper terms
    // -------------------------------------------------------------------------
    logic               xfer;
    logic               bounce_hold;
    logic               step_en;
    logic               step_hit;
    logic [DIV_W-1:0]   presc_base;
    logic [CNT_W-1:0]   step_base;

    assign cfg_ready_o = (state_q != ST_LOAD);

    // stop outranks the handshake: nothing is accepted while stop_i is high.
    assign xfer = cfg_valid_i & cfg_ready_o & ~stop_i;

    // The load cycle itself counts as prescaler tick 0, so the first shift
    // lands exactly period+1 cycles after the load strobe.
    assign presc_base = (state_q == ST_LOAD) ? '0 : presc_q;
    assign step_base  = (state_q == ST_LOAD) ? '0 : step_q;

`ifdef ROTATE_SEQ_BOUNCE_EN
    // The cycle carrying the wrap shift is spent turning the direction
    // around; no prescaler tick happens in it.
    assign bounce_hold = wrap_q;
`else
    assign bounce_hold = 1'b0;
`endif

    assign step_en  = (state_q != ST_IDLE) & run_i & ~bounce_hold;
    assign step_hit = (presc_base == period_q);

    // -------------------------------------------------------------------------
    // Process 1: state register (and the registered datapath)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            step_q   <= '0;
            period_q <= '0;
            load_q   <= 1'b0;
            shift_q  <= 1'b0;
            wrap_q   <= 1'b0;
            dir_q    <= 1'b0;
            data_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            step_q   <= step_d;
            period_q <= period_d;
            load_q   <= load_d;
            shift_q  <= shift_d;
            wrap_q   <= wrap_d;
            dir_q    <= dir_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
        end
    end

    // -------------------------------------------------------------------------
    // Process 2: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (stop_i) begin
            state_d = ST_IDLE;
        end else if (xfer) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_LOAD: state_d = ST_RUN;
                ST_RUN:  state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Process 3: output / datapath next values
    // -------------------------------------------------------------------------
    always_comb begin
        presc_d  = presc_q;
        step_d   = step_q;
        period_d = period_q;
        dir_d    = dir_q;
        data_d   = data_q;
        load_d   = 1'b0;
        shift_d  = 1'b0;
        wrap_d   = 1'b0;
        busy_d   = (state_d != ST_IDLE);

        if (stop_i) begin
            // Strobes drop; configuration and counters simply hold.
            presc_d = presc_q;
        end else if (xfer) begin
            // Accepting a configuration (also aborts a running pattern);
            // no shift is issued on the accept cycle.
            period_d = cfg_period_i;
            dir_d    = cfg_dir_i;
            data_d   = cfg_pattern_i;
            load_d   = 1'b1;
            presc_d  = '0;
            step_d   = '0;
        end else if (state_q != ST_IDLE) begin
            presc_d = presc_base;
            step_d  = step_base;
            if (bounce_hold) begin
                dir_d = ~dir_q;
            end else if (step_en) begin
                if (step_hit) begin
                    shift_d = 1'b1;
                    presc_d = '0;
                    if (step_base == STEP_LAST) begin
                        step_d = '0;
                        wrap_d = 1'b1;
                    end else begin
                        step_d = step_base + STEP_ONE;
                    end
                end else begin
                    presc_d = presc_base + PRESC_ONE;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign load_o    = load_q;
    assign shift_o   = shift_q;
    assign wrap_o    = wrap_q;
    assign dir_o     = dir_q;
    assign data_in_o = data_q;
    assign busy_o    = busy_q;

    // The downstream register must never see load and shift together.
    a_no_load_and_shift : assert property (@(posedge clk) !(load_q && shift_q));

endmodule
